// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST controller: FSM states,
// data background codes and the March C- element table.
package mbist_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    typedef logic [2:0] elem_t;

    localparam elem_t ELEM_LAST = 3'd5;

    localparam logic [1:0] BG_SOLID = 2'b00;
    localparam logic [1:0] BG_CHECK = 2'b01;
    localparam logic [1:0] BG_ROW   = 2'b10;

    // One RAM operation: read (1) or write (0), and polarity
    // (0 = background pattern, 1 = inverted pattern).
    typedef struct packed {
        logic rd;
        logic inv;
    } mop_t;

    // One march element: address direction, whether it has a second
    // op, and the ops in issue order.
    typedef struct packed {
        logic down;
        logic two;
        mop_t op0;
        mop_t op1;
    } elem_desc_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_desc_t march_elem(input elem_t e);
        elem_desc_t d;
        d = '0;
        case (e)
            3'd0:    d = 6'b0_0_00_00;
            3'd1:    d = 6'b0_1_10_01;
            3'd2:    d = 6'b0_1_11_00;
            3'd3:    d = 6'b1_1_10_01;
            3'd4:    d = 6'b1_1_11_00;
            3'd5:    d = 6'b0_0_10_00;
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic mop_t march_op(input elem_desc_t d, input logic idx);
        return idx ? d.op1 : d.op0;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// RAM-side bus of the BIST controller (chip select, read/write, address,
// write data out; read data back). master = controller, slave = RAM.
interface mbist_march_ctrl_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          ram_cs;
    logic          ram_rwbar;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport master (
        output ram_cs,
        output ram_rwbar,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_cs,
        input  ram_rwbar,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mbist_addr_gen.sv
// AW-bit up/down address counter with synchronous load.
// Ports: clk, rst (async high), load/load_val, en, down, addr, tc
// (tc = counter sits at its terminal value for the current direction).
module mbist_addr_gen #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          en,
    input  logic          down,
    output logic [AW-1:0] addr,
    output logic          tc
);

    assign tc = down ? (addr == '0) : (addr == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (en) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port synchronous SRAM.
// Ports: clk, rst (async high); start, bg_sel test request; csin/rwbarin/
// address/datain/dataout functional port; mem = RAM bus (master);
// busy, done, fail, fail_addr, fail_bits, fail_cnt status.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int AW           = 6,
    parameter int DW           = 8,
    parameter int FCW          = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          bg_sel,
    input  logic                csin,
    input  logic                rwbarin,
    input  logic [AW-1:0]       address,
    input  logic [DW-1:0]       datain,
    output logic [DW-1:0]       dataout,
    mbist_march_ctrl_if.master  mem,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [AW-1:0]       fail_addr,
    output logic [DW-1:0]       fail_bits,
    output logic [FCW-1:0]      fail_cnt
);

    state_t        state;
    elem_t         elem;
    logic          op_idx;
    logic [1:0]    bg;

    logic [AW-1:0] addr;
    logic          tc;

    elem_desc_t    desc;
    elem_desc_t    nxt_desc;
    mop_t          mop;
    elem_t         load_elem;
    logic          run;
    logic          last_op;
    logic          step;
    logic          elem_end;
    logic          start_acc;
    logic          load;
    logic          mismatch;
    logic          stop;

    logic [DW-1:0] pat;
    logic [DW-1:0] bist_data;

    logic          cmp_vld;
    logic [DW-1:0] cmp_exp;
    logic [AW-1:0] cmp_addr;

    assign desc      = march_elem(elem);
    assign mop       = march_op(desc, op_idx);
    assign run       = (state == S_RUN);
    assign last_op   = !desc.two || op_idx;
    assign step      = run && last_op;
    assign elem_end  = step && tc;
    assign start_acc = start && (state == S_IDLE || state == S_DONE);

    // The counter is reloaded with the next element's start address,
    // so an up element followed by a down one restarts at DEPTH-1.
    assign load      = start_acc || elem_end;
    assign load_elem = start_acc ? elem_t'(0) : elem + 3'd1;
    assign nxt_desc  = march_elem(load_elem);

    mbist_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val ({AW{nxt_desc.down}}),
        .en       (step),
        .down     (desc.down),
        .addr     (addr),
        .tc       (tc)
    );

    always_comb begin
        pat = '0;
        case (bg)
            BG_SOLID: pat = '0;
            BG_CHECK: begin
                for (int i = 0; i < DW; i++) begin
                    pat[i] = (i % 2 == 0);
                end
            end
            BG_ROW:   pat = addr[0] ? '1 : '0;
            default:  pat = '0;
        endcase
    end

    assign bist_data = mop.inv ? ~pat : pat;

    // Read data for the op registered last cycle is on ram_rdata now.
    assign mismatch = cmp_vld && (mem.ram_rdata != cmp_exp);
    assign stop     = (STOP_ON_FAIL != 0) && mismatch;

    assign dataout = mem.ram_rdata;

    always_comb begin
        mem.ram_cs    = csin;
        mem.ram_rwbar = rwbarin;
        mem.ram_addr  = address;
        mem.ram_wdata = datain;
        if (busy) begin
            mem.ram_cs    = 1'b1;
            // DRAIN issues a harmless read so the RAM is never written.
            mem.ram_rwbar = run ? mop.rd : 1'b1;
            mem.ram_addr  = addr;
            mem.ram_wdata = bist_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            elem      <= '0;
            op_idx    <= 1'b0;
            bg        <= BG_SOLID;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_bits <= '0;
            fail_cnt  <= '0;
            cmp_vld   <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
        end else begin
            cmp_vld  <= run && mop.rd;
            cmp_exp  <= bist_data;
            cmp_addr <= addr;

            if (mismatch) begin
                fail <= 1'b1;
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + FCW'(1);
                end
                if (!fail) begin
                    fail_addr <= cmp_addr;
                    fail_bits <= cmp_exp ^ mem.ram_rdata;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        elem      <= '0;
                        op_idx    <= 1'b0;
                        bg        <= bg_sel;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_bits <= '0;
                        fail_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (stop || (elem_end && elem == ELEM_LAST)) begin
                        state <= S_DRAIN;
                    end else if (last_op) begin
                        op_idx <= 1'b0;
                        if (tc) begin
                            elem <= elem + 3'd1;
                        end
                    end else begin
                        op_idx <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (run-to-end and stop-on-fail)
// share one stimulus stream, each with a stuck-at fault-injecting RAM.
module tb_mbist_march_ctrl;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int DEPTH = 64;
    localparam int T_END = 10 * DEPTH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    bg_sel;
    logic          csin;
    logic          rwbarin;
    logic [AW-1:0] address;
    logic [DW-1:0] datain;

    logic [DW-1:0] dout0, dout1;
    logic          busy0, busy1, done0, done1, fail0, fail1;
    logic [AW-1:0] faddr0, faddr1;
    logic [DW-1:0] fbits0, fbits1;
    logic [7:0]    fcnt0, fcnt1;

    int checks = 0;
    int failures = 0;

    logic [7:0] sa1 [DEPTH];
    logic [7:0] sa0 [DEPTH];
    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];

    mbist_march_ctrl_if #(.AW(AW), .DW(DW)) bus0 ();
    mbist_march_ctrl_if #(.AW(AW), .DW(DW)) bus1 ();

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .AW(AW), .DW(DW), .FCW(8), .STOP_ON_FAIL(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .bg_sel(bg_sel),
        .csin(csin), .rwbarin(rwbarin), .address(address),
        .datain(datain), .dataout(dout0), .mem(bus0),
        .busy(busy0), .done(done0), .fail(fail0),
        .fail_addr(faddr0), .fail_bits(fbits0), .fail_cnt(fcnt0)
    );

    mbist_march_ctrl #(
        .AW(AW), .DW(DW), .FCW(8), .STOP_ON_FAIL(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .bg_sel(bg_sel),
        .csin(csin), .rwbarin(rwbarin), .address(address),
        .datain(datain), .dataout(dout1), .mem(bus1),
        .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(faddr1), .fail_bits(fbits1), .fail_cnt(fcnt1)
    );

    // Synchronous RAMs, read latency 1, stuck-at faults applied on read.
    always_ff @(posedge clk) begin
        if (bus0.ram_cs) begin
            if (bus0.ram_rwbar)
                bus0.ram_rdata <= (mem0[bus0.ram_addr] | sa1[bus0.ram_addr])
                                  & ~sa0[bus0.ram_addr];
            else
                mem0[bus0.ram_addr] <= bus0.ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (bus1.ram_cs) begin
            if (bus1.ram_rwbar)
                bus1.ram_rdata <= (mem1[bus1.ram_addr] | sa1[bus1.ram_addr])
                                  & ~sa0[bus1.ram_addr];
            else
                mem1[bus1.ram_addr] <= bus1.ram_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit fail;
        int addr;
        int bits;
        int cnt;
        int first_op;
    } res_t;

    string march_s [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    bit    march_dn [6] = '{0, 0, 0, 1, 1, 0};

    function automatic logic [7:0] bgpat(input logic [1:0] bg, input int a);
        case (bg)
            2'b01:   return 8'h55;
            2'b10:   return (a % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // Walks the march as nested loops over a plain memory array; with
    // stop set, only the failing op and the one issued beside it count.
    function automatic void model(input logic [1:0] bg, input bit stop,
                                  output res_t r);
        logic [7:0] m [DEPTH];
        logic [7:0] v, got;
        int op, lim, a;
        r.fail = 0; r.addr = 0; r.bits = 0; r.cnt = 0; r.first_op = -1;
        op = 0;
        lim = 10 * DEPTH;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = march_dn[e] ? DEPTH - 1 - k : k;
                for (int j = 0; j < march_s[e].len(); j += 2) begin
                    if (op < lim) begin
                        v = bgpat(bg, a);
                        if (march_s[e][j+1] == "1") v = ~v;
                        if (march_s[e][j] == "w") begin
                            m[a] = v;
                        end else begin
                            got = (m[a] | sa1[a]) & ~sa0[a];
                            if (got != v) begin
                                if (!r.fail) begin
                                    r.fail = 1;
                                    r.addr = a;
                                    r.bits = int'(got ^ v);
                                    r.first_op = op;
                                    if (stop) lim = op + 2;
                                end
                                if (r.cnt < 255) r.cnt++;
                            end
                        end
                    end
                    op++;
                end
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    task automatic start_run(input logic [1:0] bg);
        @(negedge clk);
        bg_sel = bg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // k0: edges already elapsed since the start edge.
    task automatic wait_done(input int k0, input int pulse_at,
                             output int n0, output int n1);
        int k;
        k = k0;
        n0 = -1;
        n1 = -1;
        while ((n0 < 0 || n1 < 0) && k < 1000) begin
            if (k + 1 == pulse_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
            if (n0 < 0 && done0) n0 = k;
            if (n1 < 0 && done1) n1 = k;
        end
    endtask

    function automatic int stop_done(input res_t r);
        if (r.first_op < 0) return T_END;
        return (r.first_op + 3 < T_END) ? r.first_op + 3 : T_END;
    endfunction

    task automatic check_result(input string tag, input res_t m0,
                                input res_t m1, input int n0, input int n1);
        chk({tag, ".done_t"}, n0, T_END);
        chk({tag, ".done_t_s"}, n1, stop_done(m1));
        chk({tag, ".fail"}, 32'(fail0), 32'(m0.fail));
        chk({tag, ".fail_addr"}, 32'(faddr0), m0.addr);
        chk({tag, ".fail_bits"}, 32'(fbits0), m0.bits);
        chk({tag, ".fail_cnt"}, 32'(fcnt0), m0.cnt);
        chk({tag, ".fail_s"}, 32'(fail1), 32'(m1.fail));
        chk({tag, ".fail_addr_s"}, 32'(faddr1), m1.addr);
        chk({tag, ".fail_bits_s"}, 32'(fbits1), m1.bits);
        chk({tag, ".fail_cnt_s"}, 32'(fcnt1), m1.cnt);
        chk({tag, ".busy"}, 32'({busy0, busy1}), 32'(0));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0] bg;
        bit         has_f;
        logic [5:0] fa;
        logic [7:0] fm;
        bit         sa_one;
        bit         e_fail;
        logic [5:0] e_addr;
        logic [7:0] e_bits;
        int         e_cnt;
        int         e_cnt_s;
        int         e_done_s;
    } vec_t;

    vec_t vecs [5];

    initial begin
        res_t m0, m1;
        int n0, n1;
        int nf, fa, fb;
        logic [1:0] rbg;

        vecs[0] = '{2'b00, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0, 0, 641};
        vecs[1] = '{2'b00, 1, 6'h15, 8'h08, 1, 1, 6'h15, 8'h08, 3, 1, 109};
        vecs[2] = '{2'b01, 1, 6'h20, 8'h01, 0, 1, 6'h20, 8'h01, 3, 1, 131};
        vecs[3] = '{2'b10, 1, 6'h01, 8'h80, 1, 1, 6'h01, 8'h80, 2, 1, 197};
        vecs[4] = '{2'b11, 1, 6'h3F, 8'h01, 0, 1, 6'h3F, 8'h01, 2, 1, 321};

        rst = 1'b1;
        start = 1'b0;
        bg_sel = 2'b00;
        csin = 1'b0;
        rwbarin = 1'b1;
        address = 6'h11;
        datain = 8'h00;
        clear_faults();

        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy0), 0);
        chk("rst.done", 32'(done0), 0);
        chk("rst.fail", 32'(fail0), 0);
        chk("rst.fail_cnt", 32'(fcnt0), 0);
        chk("rst.fail_addr", 32'(faddr0), 0);
        chk("rst.ram_addr", 32'(bus0.ram_addr), 32'h11);
        chk("rst.ram_cs", 32'(bus0.ram_cs), 0);
        @(negedge clk);
        rst = 1'b0;

        // Checkerboard background: E0 writes 0x55, E1 writes 0xAA.
        start_run(2'b01);
        chk("bg01.busy", 32'(busy0), 1);
        chk("bg01.e0_cs", 32'(bus0.ram_cs), 1);
        chk("bg01.e0_rw", 32'(bus0.ram_rwbar), 0);
        chk("bg01.e0_addr", 32'(bus0.ram_addr), 0);
        chk("bg01.e0_wdata", 32'(bus0.ram_wdata), 32'h55);
        repeat (64) begin @(posedge clk); #1; end
        chk("bg01.e1_rd", 32'(bus0.ram_rwbar), 1);
        @(posedge clk); #1;
        chk("bg01.e1_rw", 32'(bus0.ram_rwbar), 0);
        chk("bg01.e1_addr", 32'(bus0.ram_addr), 0);
        chk("bg01.e1_wdata", 32'(bus0.ram_wdata), 32'hAA);
        chk("bg01.dataout", 32'(dout0), 32'(bus0.ram_rdata));
        wait_done(65, 0, n0, n1);
        model(2'b01, 0, m0);
        model(2'b01, 1, m1);
        check_result("bg01", m0, m1, n0, n1);

        // Row stripe background: odd addresses take all-ones in E0.
        start_run(2'b10);
        chk("bg10.a0_wdata", 32'(bus0.ram_wdata), 32'h00);
        @(posedge clk); #1;
        chk("bg10.a1_addr", 32'(bus0.ram_addr), 1);
        chk("bg10.a1_wdata", 32'(bus0.ram_wdata), 32'hFF);
        wait_done(1, 0, n0, n1);
        model(2'b10, 0, m0);
        model(2'b10, 1, m1);
        check_result("bg10", m0, m1, n0, n1);

        for (int v = 0; v < 5; v++) begin
            clear_faults();
            if (vecs[v].has_f) begin
                if (vecs[v].sa_one) sa1[vecs[v].fa] = vecs[v].fm;
                else                sa0[vecs[v].fa] = vecs[v].fm;
            end
            start_run(vecs[v].bg);
            wait_done(0, 0, n0, n1);
            chk($sformatf("vec%0d.done_t", v), n0, T_END);
            chk($sformatf("vec%0d.done_t_s", v), n1, vecs[v].e_done_s);
            chk($sformatf("vec%0d.fail", v), 32'(fail0), 32'(vecs[v].e_fail));
            chk($sformatf("vec%0d.fail_addr", v), 32'(faddr0),
                32'(vecs[v].e_addr));
            chk($sformatf("vec%0d.fail_bits", v), 32'(fbits0),
                32'(vecs[v].e_bits));
            chk($sformatf("vec%0d.fail_cnt", v), 32'(fcnt0), vecs[v].e_cnt);
            chk($sformatf("vec%0d.fail_cnt_s", v), 32'(fcnt1),
                vecs[v].e_cnt_s);
            chk($sformatf("vec%0d.fail_addr_s", v), 32'(faddr1),
                32'(vecs[v].e_addr));
        end

        // Restart after a failing run, fault removed, stray start mid-run.
        clear_faults();
        start_run(2'b00);
        chk("restart.fail_clr", 32'(fail0), 0);
        chk("restart.cnt_clr", 32'(fcnt0), 0);
        chk("restart.done_clr", 32'(done0), 0);
        wait_done(0, 50, n0, n1);
        model(2'b00, 0, m0);
        model(2'b00, 1, m1);
        check_result("restart", m0, m1, n0, n1);

        // Asynchronous reset in the middle of a failing run.
        clear_faults();
        sa1[6'h15] = 8'h08;
        start_run(2'b00);
        repeat (120) begin @(posedge clk); #1; end
        chk("midrst.fail_before", 32'(fail0), 1);
        address = 6'h2A;
        csin = 1'b1;
        rwbarin = 1'b0;
        datain = 8'h3C;
        rst = 1'b1;
        #1;
        chk("midrst.busy", 32'({busy0, busy1}), 0);
        chk("midrst.done", 32'({done0, done1}), 0);
        chk("midrst.fail", 32'({fail0, fail1}), 0);
        chk("midrst.fail_cnt", 32'(fcnt0), 0);
        chk("midrst.ram_addr", 32'(bus0.ram_addr), 32'h2A);
        chk("midrst.ram_rw", 32'(bus0.ram_rwbar), 0);
        chk("midrst.ram_wdata", 32'(bus0.ram_wdata), 32'h3C);
        @(negedge clk);
        rst = 1'b0;
        csin = 1'b0;
        rwbarin = 1'b1;

        // Every read fails: 320 miscompares saturate the counter.
        for (int i = 0; i < DEPTH; i++) begin
            sa1[i] = 8'h01;
            sa0[i] = 8'h02;
        end
        start_run(2'b00);
        wait_done(0, 0, n0, n1);
        model(2'b00, 0, m0);
        model(2'b00, 1, m1);
        check_result("sat", m0, m1, n0, n1);
        chk("sat.cnt_max", 32'(fcnt0), 32'hFF);

        for (int r = 0; r < 6; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                fa = $urandom_range(0, DEPTH - 1);
                fb = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) sa1[fa][fb] = 1'b1;
                else                           sa0[fa][fb] = 1'b1;
            end
            rbg = 2'($urandom_range(0, 3));
            model(rbg, 0, m0);
            model(rbg, 1, m1);
            start_run(rbg);
            wait_done(0, 0, n0, n1);
            check_result($sformatf("rand%0d", r), m0, m1, n0, n1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
